image_readout: RTL and testbench

Byte-stream readout stage that sits directly downstream of the camera image buffer in the SPI clock domain. It walks the buffer's byte address space from 0 to `image_size_in - 1`, holds each address stable for the buffer's full read latency, and captures the returned byte into a small prefetch FIFO. The SPI register interface then pops bytes one per request. Reads are suspended while a capture is writing the buffer, because buffer writes take the shared address port.

---
 rtl/image_readout.sv | 211 +++++++++++++++++++++
 tb/tb_image_readout.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_readout.sv
`default_nettype none
// ============================================================================
//  Module   : image_readout
//  Purpose  : Byte-stream readout stage behind the camera image buffer.
//             Walks addresses 0 .. size-1, holds each address for the full
//             buffer read latency, captures the returned byte into a small
//             prefetch FIFO and hands bytes out one per pop request.
//             Reads are suspended while a capture owns the buffer port.
//  Ports    : spi_clock_in       - clock (SPI/system domain)
//             spi_reset_n_in     - asynchronous active-low reset
//             start_in           - flush, latch image_size_in, restart at 0
//             image_size_in      - byte count, sampled on start_in
//             capture_active_in  - buffer write in progress, abort/hold reads
//             read_address_out   - address to the image buffer read port
//             read_data_in       - byte returned by the image buffer
//             byte_request_in    - pop request from the SPI interface
//             byte_data_out      - FIFO head (0x00 when empty)
//             byte_valid_out     - FIFO non-empty
//             underrun_out       - sticky pop-while-empty flag
//             done_out           - every byte of the image has been popped
//  Revision : 1.0 - initial release
// ============================================================================
module image_readout #(
   parameter int READ_LATENCY = 2,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        spi_clock_in,
   input  logic        spi_reset_n_in,
   input  logic        start_in,
   input  logic [15:0] image_size_in,
   input  logic        capture_active_in,
   output logic [15:0] read_address_out,
   input  logic [7:0]  read_data_in,
   input  logic        byte_request_in,
   output logic [7:0]  byte_data_out,
   output logic        byte_valid_out,
   output logic        underrun_out,
   output logic        done_out
);

   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;

   localparam logic [1:0] c_IDLE    = 2'd0;
   localparam logic [1:0] c_ADDR    = 2'd1;
   localparam logic [1:0] c_CAPTURE = 2'd2;
   localparam logic [1:0] c_DONE    = 2'd3;

   logic [1:0]         r_state;
   logic [15:0]        r_size;
   logic [15:0]        r_fetch_ptr;
   logic [15:0]        r_pop_count;
   logic [2:0]         r_wait_cnt;
   logic               r_fetch_done;
   logic [7:0]         r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;
   logic [7:0]         r_byte_data;
   logic               r_byte_valid;
   logic               r_underrun;
   logic               r_done;

   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_last_fetch;
   logic               w_final_pop;
   logic               w_issue;
   logic               w_lat_done;
   logic [c_PTR_W-1:0] w_rd_ptr_inc;
   logic [c_CNT_W-1:0] w_count_next;
   logic [7:0]         w_head_next;

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == c_CNT_W'(FIFO_DEPTH));
   // start_in wins over everything else in the same cycle
   assign w_pop        = byte_request_in && !w_empty && !start_in;
   assign w_push       = (r_state == c_CAPTURE) && !capture_active_in && !start_in;
   assign w_last_fetch = (r_fetch_ptr == r_size - 16'd1);
   assign w_final_pop  = w_pop && ((r_pop_count + 16'd1) == r_size);
   // A read only counts down its latency while the FIFO can accept the byte,
   // more bytes remain and the buffer port is not owned by a capture.
   assign w_issue      = !r_fetch_done && !w_full && !capture_active_in;
   assign w_lat_done   = (r_wait_cnt == 3'(READ_LATENCY - 1));
   assign w_rd_ptr_inc = r_rd_ptr + 1'b1;

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop) begin
         w_count_next = r_count + 1'b1;
      end else if (!w_push && w_pop) begin
         w_count_next = r_count - 1'b1;
      end
   end

   // Registered head: next entry after a pop, or the byte being pushed when
   // it lands in an empty (or just-emptied) FIFO.
   always_comb begin
      w_head_next = r_byte_data;
      if (w_pop) begin
         if (r_count > c_CNT_W'(1)) begin
            w_head_next = r_mem[w_rd_ptr_inc];
         end else if (w_push) begin
            w_head_next = read_data_in;
         end else begin
            w_head_next = 8'h00;
         end
      end else if (w_empty && w_push) begin
         w_head_next = read_data_in;
      end
   end

   always_ff @(posedge spi_clock_in) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= read_data_in;
      end
   end

   always_ff @(posedge spi_clock_in or negedge spi_reset_n_in) begin
      if (!spi_reset_n_in) begin
         r_state      <= c_IDLE;
         r_size       <= 16'd0;
         r_fetch_ptr  <= 16'd0;
         r_pop_count  <= 16'd0;
         r_wait_cnt   <= 3'd0;
         r_fetch_done <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_byte_data  <= 8'h00;
         r_byte_valid <= 1'b0;
         r_underrun   <= 1'b0;
         r_done       <= 1'b0;
      end else if (start_in) begin
         r_size       <= image_size_in;
         r_fetch_ptr  <= 16'd0;
         r_pop_count  <= 16'd0;
         r_wait_cnt   <= 3'd0;
         r_fetch_done <= 1'b0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_byte_data  <= 8'h00;
         r_byte_valid <= 1'b0;
         r_underrun   <= 1'b0;
         if (image_size_in == 16'd0) begin
            r_state <= c_DONE;
            r_done  <= 1'b1;
         end else begin
            r_state <= c_ADDR;
            r_done  <= 1'b0;
         end
      end else begin
         if (byte_request_in && w_empty) begin
            r_underrun <= 1'b1;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr    <= w_rd_ptr_inc;
            r_pop_count <= r_pop_count + 16'd1;
         end
         r_count      <= w_count_next;
         r_byte_valid <= (w_count_next != '0);
         r_byte_data  <= w_head_next;

         case (r_state)
            c_ADDR: begin
               if (w_final_pop) begin
                  r_state <= c_DONE;
                  r_done  <= 1'b1;
               end else if (w_issue) begin
                  if (w_lat_done) begin
                     r_state    <= c_CAPTURE;
                     r_wait_cnt <= 3'd0;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + 3'd1;
                  end
               end else begin
                  r_wait_cnt <= 3'd0;
               end
            end
            c_CAPTURE: begin
               // Aborted captures fall back to ADDR on the same address.
               r_state    <= c_ADDR;
               r_wait_cnt <= 3'd0;
               if (w_push) begin
                  if (w_last_fetch) begin
                     r_fetch_done <= 1'b1;
                  end else begin
                     r_fetch_ptr <= r_fetch_ptr + 16'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign read_address_out = r_fetch_ptr;
   assign byte_data_out    = r_byte_data;
   assign byte_valid_out   = r_byte_valid;
   assign underrun_out     = r_underrun;
   assign done_out         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_image_readout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_image_readout
//  Purpose  : Self-checking bench for image_readout. Three instances cover
//             read latencies 2, 1 and 4, each with its own buffer model
//             that only returns addr & 0xFF once the address has been
//             stable for the full latency (0xEE otherwise).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_image_readout;

   typedef struct {
      int sel;          // 0: latency 2, 1: latency 1, 2: latency 4
      int size;
      int hold;         // cycles with no pops after start
      int cap_addr;     // address whose wait gets a capture window (-1 none)
      int cap_len;
      int first_valid;  // cycle of first byte_valid after start
      int rs_pops;      // restart after this many pops (0 none)
      int rs_size;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_s [3];
   logic [15:0] size_s;
   logic        cap_s;
   logic        req_s [3];
   logic [15:0] addr [3];
   logic [7:0]  rdata [3];
   logic [7:0]  bdata [3];
   logic        bvalid [3];
   logic        underrun [3];
   logic        done [3];
   logic [15:0] apipe [3][8];

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  exp_q [$];
   vec_t        vecs [8];

   always #5 clk = ~clk;

   image_readout #(.READ_LATENCY(2), .FIFO_DEPTH(4)) u_dut0 (
      .spi_clock_in(clk), .spi_reset_n_in(rst_n), .start_in(start_s[0]),
      .image_size_in(size_s), .capture_active_in(cap_s),
      .read_address_out(addr[0]), .read_data_in(rdata[0]),
      .byte_request_in(req_s[0]), .byte_data_out(bdata[0]),
      .byte_valid_out(bvalid[0]), .underrun_out(underrun[0]), .done_out(done[0]));

   image_readout #(.READ_LATENCY(1), .FIFO_DEPTH(4)) u_dut1 (
      .spi_clock_in(clk), .spi_reset_n_in(rst_n), .start_in(start_s[1]),
      .image_size_in(size_s), .capture_active_in(cap_s),
      .read_address_out(addr[1]), .read_data_in(rdata[1]),
      .byte_request_in(req_s[1]), .byte_data_out(bdata[1]),
      .byte_valid_out(bvalid[1]), .underrun_out(underrun[1]), .done_out(done[1]));

   image_readout #(.READ_LATENCY(4), .FIFO_DEPTH(4)) u_dut2 (
      .spi_clock_in(clk), .spi_reset_n_in(rst_n), .start_in(start_s[2]),
      .image_size_in(size_s), .capture_active_in(cap_s),
      .read_address_out(addr[2]), .read_data_in(rdata[2]),
      .byte_request_in(req_s[2]), .byte_data_out(bdata[2]),
      .byte_valid_out(bvalid[2]), .underrun_out(underrun[2]), .done_out(done[2]));

   function automatic int lat_of(input int sel);
      case (sel)
         1:       return 1;
         2:       return 4;
         default: return 2;
      endcase
   endfunction

   // Address history: apipe[d][k] is the address presented k+1 cycles ago.
   always @(posedge clk) begin
      for (int d = 0; d < 3; d++) begin
         apipe[d][0] <= addr[d];
         for (int k = 1; k < 8; k++) apipe[d][k] <= apipe[d][k-1];
      end
   end

   always_comb begin
      for (int d = 0; d < 3; d++) begin
         logic ok;
         ok = 1'b1;
         for (int k = 0; k < 8; k++) begin
            if (k < lat_of(d) && apipe[d][k] !== addr[d]) ok = 1'b0;
         end
         rdata[d] = ok ? addr[d][7:0] : 8'hEE;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int s = v.sel;
      int lat = lat_of(v.sel);
      int cyc = 0;
      int first_seen = -1;
      int pops = 0;
      int last_pop_cyc = -10;
      int max_addr = 0;
      int cap_start = -1;
      int b_seen = -1;
      int size_eff = v.size;
      bit restarted = 1'b0;
      bit finished = 1'b0;
      int hold_addr = (v.size > 4) ? 4 : v.size - 1;

      @(negedge clk);
      exp_q.delete();
      for (int i = 0; i < v.size; i++) exp_q.push_back(8'(i));
      start_s[s] = 1'b1;
      size_s     = 16'(v.size);
      req_s[s]   = 1'b0;

      while (!finished && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         start_s[s] = 1'b0;
         req_s[s]   = 1'b0;

         if (cyc == 1) begin
            check("start_addr", addr[s], 0);
            check("start_valid_flushed", bvalid[s], 0);
            check("start_done", done[s], 0);
            check("start_underrun", underrun[s], 0);
         end
         if (int'(addr[s]) > max_addr) max_addr = int'(addr[s]);
         if (bvalid[s] && first_seen < 0) begin
            first_seen = cyc;
            check("first_valid_cycle", cyc, v.first_valid);
         end

         if (v.cap_addr >= 0 && !restarted) begin
            if (cap_start < 0 && int'(addr[s]) == v.cap_addr) cap_start = cyc;
            cap_s = (cap_start >= 0 && cyc < cap_start + v.cap_len);
            if (cap_start >= 0 && cyc == cap_start + v.cap_len)
               check("cap_addr_held", addr[s], v.cap_addr);
            if (cap_start >= 0 && b_seen < 0 && bvalid[s] && int'(bdata[s]) == v.cap_addr) begin
               b_seen = cyc;
               check("cap_reread_cycle", cyc, cap_start + v.cap_len + lat + 1);
            end
         end

         if (v.hold > 0 && cyc == v.hold) begin
            check("hold_addr", addr[s], hold_addr);
            check("hold_max_addr", max_addr, hold_addr);
            check("hold_valid", bvalid[s], 1);
         end

         if (done[s]) begin
            check("done_cycle", cyc, last_pop_cyc + 1);
            check("all_popped", exp_q.size(), 0);
            finished = 1'b1;
         end else if (cyc > v.hold && bvalid[s]) begin
            if (!restarted && v.rs_pops > 0 && pops == v.rs_pops) begin
               // restart together with a pop; the pop must be ignored
               start_s[s] = 1'b1;
               size_s     = 16'(v.rs_size);
               req_s[s]   = 1'b1;
               exp_q.delete();
               for (int i = 0; i < v.rs_size; i++) exp_q.push_back(8'(i));
               restarted  = 1'b1;
               size_eff   = v.rs_size;
               cyc        = 0;
               first_seen = -1;
               pops       = 0;
               max_addr   = 0;
            end else begin
               if (exp_q.size() == 0) check("extra_byte", bdata[s], 32'hFFFF_FFFF);
               else check("byte", bdata[s], exp_q.pop_front());
               req_s[s]     = 1'b1;
               pops++;
               last_pop_cyc = cyc;
            end
         end
      end
      cap_s = 1'b0;
      if (!finished) check("run_timeout", 0, 1);
      check("max_addr", max_addr, size_eff - 1);
   endtask

   initial begin
      vecs[0] = '{sel:0, size:5,  hold:0,  cap_addr:-1, cap_len:0, first_valid:4, rs_pops:0, rs_size:0};
      vecs[1] = '{sel:0, size:10, hold:50, cap_addr:-1, cap_len:0, first_valid:4, rs_pops:0, rs_size:0};
      vecs[2] = '{sel:0, size:5,  hold:0,  cap_addr:2,  cap_len:6, first_valid:4, rs_pops:0, rs_size:0};
      vecs[3] = '{sel:0, size:8,  hold:0,  cap_addr:-1, cap_len:0, first_valid:4, rs_pops:3, rs_size:3};
      vecs[4] = '{sel:1, size:16, hold:0,  cap_addr:-1, cap_len:0, first_valid:3, rs_pops:0, rs_size:0};
      vecs[5] = '{sel:2, size:16, hold:0,  cap_addr:-1, cap_len:0, first_valid:6, rs_pops:0, rs_size:0};
      vecs[6] = '{sel:0, size:1,  hold:0,  cap_addr:-1, cap_len:0, first_valid:4, rs_pops:0, rs_size:0};
      vecs[7] = '{sel:1, size:9,  hold:30, cap_addr:-1, cap_len:0, first_valid:3, rs_pops:0, rs_size:0};

      rst_n  = 1'b0;
      size_s = 16'd0;
      cap_s  = 1'b0;
      for (int d = 0; d < 3; d++) begin
         start_s[d] = 1'b0;
         req_s[d]   = 1'b0;
      end
      repeat (10) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int d = 0; d < 3; d++) begin
         check("reset_addr", addr[d], 0);
         check("reset_data", bdata[d], 0);
         check("reset_valid", bvalid[d], 0);
         check("reset_underrun", underrun[d], 0);
         check("reset_done", done[d], 0);
      end

      foreach (vecs[i]) run_vec(vecs[i]);

      // Underrun: DUT0 sits in DONE with an empty FIFO.
      @(negedge clk);
      check("pre_underrun", underrun[0], 0);
      req_s[0] = 1'b1;
      @(negedge clk);
      req_s[0] = 1'b0;
      check("underrun_set", underrun[0], 1);
      check("underrun_data", bdata[0], 0);
      repeat (20) @(negedge clk);
      check("underrun_sticky", underrun[0], 1);

      // Zero-size start clears underrun and finishes immediately.
      start_s[0] = 1'b1;
      size_s     = 16'd0;
      @(negedge clk);
      start_s[0] = 1'b0;
      check("zero_underrun", underrun[0], 0);
      check("zero_done", done[0], 1);
      check("zero_valid", bvalid[0], 0);
      check("zero_addr", addr[0], 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
